// File: rtl/timing_unit_if.sv
// timing_unit_if: control-register inputs and status outputs of the timing unit
interface timing_unit_if #(parameter int WIDTH = 32);
  logic             ro_trig_start;
  logic             ro_trig_halt;
  logic             ro_mode;
  logic [WIDTH-1:0] ro_termcount;
  logic             rf_status;
  logic [WIDTH-1:0] rf_currcount;
  logic             rf_int;
  modport master (output ro_trig_start, ro_trig_halt, ro_mode, ro_termcount,
                  input rf_status, rf_currcount, rf_int);
  modport slave (input ro_trig_start, ro_trig_halt, ro_mode, ro_termcount,
                 output rf_status, rf_currcount, rf_int);
endinterface

// File: rtl/timing_unit.sv
// timing_unit: programmable up-counting one-shot/periodic timer with terminal interrupt
// TIMING_INT_LATCH_EN: hold rf_int until a start or halt is accepted
module timing_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    timing_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] count, next_count;
    logic int_q, next_int;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            int_q <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            int_q <= next_int;
        end
    end
    always_comb begin
        next_state = state;
        next_count = count;
`ifdef TIMING_INT_LATCH_EN
        next_int = int_q;
`else
        next_int = 1'b0;
`endif
        if (state == IDLE) begin
            if (bus.ro_trig_start && !bus.ro_trig_halt) begin
                next_count = '0;
                next_state = RUN;
                next_int = 1'b0;
            end
        end else if (bus.ro_trig_halt) begin
            next_state = IDLE;
            next_int = 1'b0;
        end else if (bus.ro_trig_start) begin
            next_count = '0;
            next_int = 1'b0;
        end else if (count >= bus.ro_termcount) begin
            next_int = 1'b1;
            next_count = bus.ro_mode ? '0 : count;
            next_state = bus.ro_mode ? RUN : IDLE;
        end else begin
            next_count = count + 1'b1;
        end
    end
    assign bus.rf_status = (state == RUN);
    assign bus.rf_currcount = count;
    assign bus.rf_int = int_q;
endmodule

// File: tb/tb_timing_unit.sv
// tb_timing_unit: directed self-checking bench for timing_unit (default build)
module tb_timing_unit;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    timing_unit_if #(.WIDTH(32)) bus ();
    timing_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1 time unit after the active edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic s, input logic h);
        bus.ro_trig_start = s;
        bus.ro_trig_halt = h;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(1'b1, 1'b0);
        bus.ro_mode = 1'b0;
        bus.ro_termcount = 32'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.rf_status, bus.rf_int} !== 2'b00 || bus.rf_currcount !== 32'd0) begin
                bad++;
                $display("FAIL reset[%0d]: status=%b int=%b count=%0d required 0 0 0", i, bus.rf_status, bus.rf_int, bus.rf_currcount);
            end
        end
        reset = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        total++;
        if (bus.rf_status !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: status=%b required 0", bus.rf_status);
        end
    endtask

    task automatic test_oneshot;
        bus.ro_mode = 1'b0;
        bus.ro_termcount = 32'd3;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) tick();
            total++;
            if (bus.rf_currcount !== 32'(i) || bus.rf_status !== 1'b1 || bus.rf_int !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_count[%0d]: count=%0d status=%b int=%b required %0d 1 0", i, bus.rf_currcount, bus.rf_status, bus.rf_int, i);
            end
        end
        tick();
        total++;
        if (bus.rf_currcount !== 32'd3 || bus.rf_status !== 1'b0 || bus.rf_int !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_term: count=%0d status=%b int=%b required 3 0 1", bus.rf_currcount, bus.rf_status, bus.rf_int);
        end
        tick();
        total++;
        if (bus.rf_currcount !== 32'd3 || bus.rf_status !== 1'b0 || bus.rf_int !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_after: count=%0d status=%b int=%b required 3 0 0", bus.rf_currcount, bus.rf_status, bus.rf_int);
        end
    endtask

    task automatic test_periodic;
        logic [31:0] exp_c [6] = '{1, 2, 0, 1, 2, 0};
        logic exp_i [6] = '{0, 0, 1, 0, 0, 1};
        bus.ro_mode = 1'b1;
        bus.ro_termcount = 32'd2;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_currcount !== 32'd0 || bus.rf_status !== 1'b1) begin
            bad++;
            $display("FAIL periodic_start: count=%0d status=%b required 0 1", bus.rf_currcount, bus.rf_status);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.rf_currcount !== exp_c[i] || bus.rf_int !== exp_i[i] || bus.rf_status !== 1'b1) begin
                bad++;
                $display("FAIL periodic[%0d]: count=%0d int=%b status=%b required %0d %b 1", i, bus.rf_currcount, bus.rf_int, bus.rf_status, exp_c[i], exp_i[i]);
            end
        end
        drive(1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0);
    endtask

    task automatic test_halt;
        bus.ro_mode = 1'b0;
        bus.ro_termcount = 32'd100;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick(5);
        drive(1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_currcount !== 32'd5 || bus.rf_status !== 1'b0 || bus.rf_int !== 1'b0) begin
            bad++;
            $display("FAIL halt: count=%0d status=%b int=%b required 5 0 0", bus.rf_currcount, bus.rf_status, bus.rf_int);
        end
        tick(2);
        total++;
        if (bus.rf_currcount !== 32'd5 || bus.rf_status !== 1'b0) begin
            bad++;
            $display("FAIL halt_frozen: count=%0d status=%b required 5 0", bus.rf_currcount, bus.rf_status);
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_currcount !== 32'd0 || bus.rf_status !== 1'b1) begin
            bad++;
            $display("FAIL halt_restart: count=%0d status=%b required 0 1", bus.rf_currcount, bus.rf_status);
        end
    endtask

    task automatic test_start_halt;
        drive(1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_status !== 1'b0) begin
            bad++;
            $display("FAIL start_halt_idle: status=%b required 0", bus.rf_status);
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick(7);
        total++;
        if (bus.rf_currcount !== 32'd7) begin
            bad++;
            $display("FAIL pre_restart: count=%0d required 7", bus.rf_currcount);
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_currcount !== 32'd0 || bus.rf_status !== 1'b1 || bus.rf_int !== 1'b0) begin
            bad++;
            $display("FAIL restart: count=%0d status=%b int=%b required 0 1 0", bus.rf_currcount, bus.rf_status, bus.rf_int);
        end
        drive(1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0);
    endtask

    task automatic test_term0;
        bus.ro_mode = 1'b1;
        bus.ro_termcount = 32'd0;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        total++;
        if (bus.rf_int !== 1'b0 || bus.rf_currcount !== 32'd0) begin
            bad++;
            $display("FAIL term0_start: int=%b count=%0d required 0 0", bus.rf_int, bus.rf_currcount);
        end
        tick();
        total++;
        if (bus.rf_int !== 1'b1 || bus.rf_status !== 1'b1 || bus.rf_currcount !== 32'd0) begin
            bad++;
            $display("FAIL term0_first: int=%b status=%b count=%0d required 1 1 0", bus.rf_int, bus.rf_status, bus.rf_currcount);
        end
        tick(2);
        total++;
        if (bus.rf_int !== 1'b1 || bus.rf_status !== 1'b1) begin
            bad++;
            $display("FAIL term0_again: int=%b status=%b required 1 1", bus.rf_int, bus.rf_status);
        end
        drive(1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0);
    endtask

    task automatic test_lower_term;
        bus.ro_mode = 1'b0;
        bus.ro_termcount = 32'd50;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick(10);
        bus.ro_termcount = 32'd4;
        tick();
        total++;
        if (bus.rf_int !== 1'b1 || bus.rf_status !== 1'b0 || bus.rf_currcount !== 32'd10) begin
            bad++;
            $display("FAIL lower_term: int=%b status=%b count=%0d required 1 0 10", bus.rf_int, bus.rf_status, bus.rf_currcount);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0);
        bus.ro_mode = 1'b0;
        bus.ro_termcount = '0;
        reset = 1'b0;
        #2;
        test_reset();
        test_oneshot();
        test_periodic();
        test_halt();
        test_start_halt();
        test_term0();
        test_lower_term();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
